latch_write_ctrl: RTL

- Writer-side controller for a bank of transparent level-sensitive latches (Latch-style storage with in/out/enable).
- Accepts write requests on a valid/ready handshake in the clk domain and presents the data on the latch input bus.
- Drives the latch gate with a glitch-free, registered enable window framed by programmable setup and hold periods, so latch data never changes while the gate is open.
- Sits between a synchronous producer and the latch bank; the latch itself stays a separate block.

---
 rtl/latch_ctrl_pkg.sv | 18 +
 rtl/latch_write_ctrl_phase_timer.sv | 34 +++
 rtl/latch_write_ctrl.sv | 133 +++++++++++++
 3 files changed

// File: rtl/latch_ctrl_pkg.sv
// Shared types and default phase lengths for the latch writer controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package latch_ctrl_pkg;

  // Write sequence phases. IDLE is the only phase in which a request is accepted.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } wr_state_t;

  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_OPEN_CYC  = 1;
  localparam int DEF_HOLD_CYC  = 1;

endpackage

// File: rtl/latch_write_ctrl_phase_timer.sv
// Loadable down-counter that times one phase of a latch write; flags zero.
// Latency: load value visible the cycle after load; zero is combinational from the count.
// Backpressure: none; the counter parks at zero until the next load.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        load load_val on the next edge (takes priority over counting)
//   load_val    remaining cycles minus one for the phase being entered
//   zero        count has reached zero (last cycle of the current phase)
module phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/latch_write_ctrl.sv
// Writer-side controller: accepts a write, then frames the latch gate with setup/open/hold phases.
// Latency: SETUP_CYC+OPEN_CYC+HOLD_CYC cycles from acceptance to IDLE; done pulses on the first IDLE cycle.
// Backpressure: wr_ready is low whenever a write is in progress; the producer must hold its request.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset (reset aborts a write immediately)
//   wr_valid/ready  write request handshake; wr_data sampled on acceptance
//   latch_in        registered data bus to the latch bank; changes only on acceptance
//   latch_en        registered latch gate, high for exactly OPEN_CYC cycles per write
//   done            one-cycle pulse when a write completes
//   busy            a write is in progress
//   wr_count        completed writes, wraps modulo 2^CNT_W
module latch_write_ctrl
  import latch_ctrl_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int OPEN_CYC  = DEF_OPEN_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  input  logic [WIDTH-1:0] wr_data,
  output logic             wr_ready,
  output logic [WIDTH-1:0] latch_in,
  output logic             latch_en,
  output logic             done,
  output logic             busy,
  output logic [CNT_W-1:0] wr_count
);

  // Every phase must last at least one cycle, and its length minus one must fit the timer.
  if (SETUP_CYC < 1 || SETUP_CYC > (1 << CNT_W)) begin : g_bad_setup
    $error("latch_write_ctrl: SETUP_CYC must be in 1..2^CNT_W");
  end
  if (OPEN_CYC < 1 || OPEN_CYC > (1 << CNT_W)) begin : g_bad_open
    $error("latch_write_ctrl: OPEN_CYC must be in 1..2^CNT_W");
  end
  if (HOLD_CYC < 1 || HOLD_CYC > (1 << CNT_W)) begin : g_bad_hold
    $error("latch_write_ctrl: HOLD_CYC must be in 1..2^CNT_W");
  end

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] OPEN_LD  = CNT_W'(OPEN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  wr_state_t        state, state_nxt;
  logic             timer_load;
  logic [CNT_W-1:0] timer_val;
  logic             timer_zero;
  logic             accept;
  logic             done_nxt;

  assign wr_ready = (state == IDLE);
  assign busy     = (state != IDLE);
  assign accept   = wr_valid && wr_ready;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .zero     (timer_zero)
  );

  // Next state; the timer is reloaded on every phase change so it always
  // counts the phase being entered.
  always_comb begin
    state_nxt  = state;
    timer_load = 1'b0;
    timer_val  = '0;
    done_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (wr_valid) begin
          state_nxt  = SETUP;
          timer_load = 1'b1;
          timer_val  = SETUP_LD;
        end
      end
      SETUP: begin
        if (timer_zero) begin
          state_nxt  = OPEN;
          timer_load = 1'b1;
          timer_val  = OPEN_LD;
        end
      end
      OPEN: begin
        if (timer_zero) begin
          state_nxt  = HOLD;
          timer_load = 1'b1;
          timer_val  = HOLD_LD;
        end
      end
      HOLD: begin
        if (timer_zero) begin
          state_nxt  = IDLE;
          timer_load = 1'b1;
          timer_val  = '0;
          done_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // The gate is a flop tracking the phase being entered, so it can only
  // change on a clock edge (or drop on reset) and never glitches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      latch_in <= '0;
      latch_en <= 1'b0;
      done     <= 1'b0;
      wr_count <= '0;
    end else begin
      state    <= state_nxt;
      latch_en <= (state_nxt == OPEN);
      done     <= done_nxt;
      if (accept) begin
        latch_in <= wr_data;
      end
      if (done_nxt) begin
        wr_count <= wr_count + CNT_W'(1);
      end
    end
  end

endmodule
